// File: rtl/ysyx_23060096_pkg.sv
// Shared decode definitions for the NPC front end: RV32I opcodes, immediate
// format selects and the decoded bundle carried by the IDU queue.
package ysyx_23060096_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] EXT_I    = 3'b000;
  localparam logic [2:0] EXT_U    = 3'b001;
  localparam logic [2:0] EXT_S    = 3'b010;
  localparam logic [2:0] EXT_B    = 3'b011;
  localparam logic [2:0] EXT_J    = 3'b100;
  localparam logic [2:0] EXT_NONE = 3'b111;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_TWO   = 2'd2
  } queueState_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  extop;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  opcode;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/ysyx_23060096_idu_ctrl_if.sv
// IFU -> IDU -> EXU handshake bundle; slave is the IDU controller,
// master is whoever drives fetch input and consumes decode output.
interface ysyx_23060096_idu_ctrl_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_extop;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [6:0]  out_opcode;
  logic        out_illegal;

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_extop,
           out_rd, out_rs1, out_rs2, out_opcode, out_illegal
  );

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_extop,
           out_rd, out_rs1, out_rs2, out_opcode, out_illegal
  );
endinterface

// File: rtl/ysyx_23060096_ImmGen.sv
// RV32I immediate generator: sign-extends the immediate of inst[31:7]
// according to the I/U/S/B/J format select. Purely combinational.
module ysyx_23060096_ImmGen
  import ysyx_23060096_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:7] inst,
  input  logic [2:0]  ExtOP,
  output logic [31:0] imm
);

  // clk/rstn are kept on the port list for existing instantiations only
  logic unusedPorts;
  assign unusedPorts = clk ^ rstn;

  always_comb begin
    imm = '0;
    case (ExtOP)
      EXT_I: imm = {{20{inst[31]}}, inst[31:20]};
      EXT_U: imm = {inst[31:12], 12'b0};
      EXT_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      EXT_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      EXT_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060096_idu_ctrl.sv
// Decode-stage controller: classifies the fetched opcode, builds the decoded
// bundle and buffers it in a two-entry head/second skid queue for the EXU.
module ysyx_23060096_idu_ctrl
  import ysyx_23060096_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ysyx_23060096_idu_ctrl_if.slave bus
);

  queueState_t state, nextState;
  decoded_t    headQ, secondQ, decIn;
  logic [2:0]  extSel, genSel;
  logic        isNone, isIllegal;
  logic [31:0] genImm;
  logic        push, pop;
  logic        loadHead, loadSecond, shiftSecond;

  always_comb begin
    extSel    = EXT_NONE;
    isIllegal = 1'b0;
    case (bus.in_inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: extSel = EXT_I;
      OP_LUI, OP_AUIPC:                    extSel = EXT_U;
      OP_STORE:                            extSel = EXT_S;
      OP_BRANCH:                           extSel = EXT_B;
      OP_JAL:                              extSel = EXT_J;
      OP_REG:                              extSel = EXT_NONE;
      default: begin
        extSel    = EXT_NONE;
        isIllegal = 1'b1;
      end
    endcase
  end

  assign isNone = (extSel == EXT_NONE);
  assign genSel = isNone ? EXT_I : extSel;

  ysyx_23060096_ImmGen uImmGen (
    .clk  (clk),
    .rstn (~rst),
    .inst (bus.in_inst[31:7]),
    .ExtOP(genSel),
    .imm  (genImm)
  );

  always_comb begin
    decIn.pc      = bus.in_pc;
    decIn.imm     = isNone ? '0 : genImm;
    decIn.extop   = extSel;
    decIn.rd      = bus.in_inst[11:7];
    decIn.rs1     = bus.in_inst[19:15];
    decIn.rs2     = bus.in_inst[24:20];
    decIn.opcode  = bus.in_inst[6:0];
    decIn.illegal = isIllegal;
  end

  // Handshake flags depend on the state register only, so in_ready has no
  // combinational path from out_ready.
  assign bus.in_ready  = (state != Q_TWO);
  assign bus.out_valid = (state != Q_EMPTY);

  assign push = bus.in_valid & bus.in_ready & ~bus.flush;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= Q_EMPTY;
    else     state <= nextState;
  end

  always_comb begin
    nextState   = state;
    loadHead    = 1'b0;
    loadSecond  = 1'b0;
    shiftSecond = 1'b0;
    case (state)
      Q_EMPTY: begin
        if (push) begin
          nextState = Q_ONE;
          loadHead  = 1'b1;
        end
      end
      Q_ONE: begin
        if (push && !pop) begin
          nextState  = Q_TWO;
          loadSecond = 1'b1;
        end else if (!push && pop) begin
          nextState = Q_EMPTY;
        end else if (push && pop) begin
          loadHead = 1'b1;
        end
      end
      Q_TWO: begin
        if (pop) begin
          nextState   = Q_ONE;
          shiftSecond = 1'b1;
        end
      end
      default: nextState = Q_EMPTY;
    endcase
    if (bus.flush) nextState = Q_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headQ   <= '0;
      secondQ <= '0;
    end else begin
      if (loadHead)         headQ <= decIn;
      else if (shiftSecond) headQ <= secondQ;
      if (loadSecond)       secondQ <= decIn;
    end
  end

  assign bus.out_pc      = headQ.pc;
  assign bus.out_imm     = headQ.imm;
  assign bus.out_extop   = headQ.extop;
  assign bus.out_rd      = headQ.rd;
  assign bus.out_rs1     = headQ.rs1;
  assign bus.out_rs2     = headQ.rs2;
  assign bus.out_opcode  = headQ.opcode;
  assign bus.out_illegal = headQ.illegal;

endmodule
